// File: rtl/axi_bridge_mp_pkg.sv
// Shared AXI3 constants and SRAM-like size encoding for the multi-port bridge.
package axi_bridge_pkg;

    localparam int unsigned ID_W       = 4;
    localparam logic [7:0]  LEN_SINGLE = 8'd0;
    localparam logic [1:0]  BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2
    } size_e;

    function automatic logic [2:0] axsize(input logic [1:0] sz);
        return {1'b0, sz};
    endfunction

endpackage

// File: rtl/axi_bridge_mp_if.sv
// Bundle of SRAM-like client ports and AXI3 master channels for axi_bridge_mp.
interface axi_bridge_mp_if #(
    parameter int unsigned NPORT = 2
) ();
    import axi_bridge_pkg::*;

    // SRAM-like side, port 0 in the LSBs
    logic [NPORT-1:0]    req;
    logic [NPORT-1:0]    wr;
    logic [2*NPORT-1:0]  size;
    logic [32*NPORT-1:0] addr;
    logic [4*NPORT-1:0]  sram_wstrb;
    logic [32*NPORT-1:0] sram_wdata;
    logic [NPORT-1:0]    addr_ok;
    logic [NPORT-1:0]    data_ok;
    logic [31:0]         rdata_o;

    logic [ID_W-1:0] arid;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid;
    logic            arready;

    logic [ID_W-1:0] rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    logic [ID_W-1:0] awid;
    logic [31:0]     awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [1:0]      awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic            awvalid;
    logic            awready;

    logic [ID_W-1:0] wid;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [ID_W-1:0] bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    modport master (
        input  req, wr, size, addr, sram_wstrb, sram_wdata,
        output addr_ok, data_ok, rdata_o,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        output req, wr, size, addr, sram_wstrb, sram_wdata,
        input  addr_ok, data_ok, rdata_o,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/axi_bridge_mp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer; pointer moves past the winner.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic            found;
    int unsigned     idx;

    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < N; off++) begin
            idx = (int'(ptr_q) + off) % N;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                if (advance) begin
                    ptr_d = PtrW'((idx + 1) % N);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/axi_bridge_mp.sv
// NPORT SRAM-like clients onto one AXI3 master: round-robin reads with per-port
// outstanding limits, a single write in flight, and a same-word read-after-write block.
module axi_bridge_mp
    import axi_bridge_pkg::*;
#(
    parameter int unsigned NPORT   = 2,
    parameter int unsigned MAX_OUT = 2
) (
    input logic             aclk,
    input logic             areset,
    axi_bridge_mp_if.master bus
);
    localparam int unsigned CntW = $clog2(MAX_OUT + 1);

    logic [31:0]      port_addr [NPORT];
    logic [NPORT-1:0] rd_elig, wr_elig, rd_gnt, wr_gnt, rd_acc, rd_dec, data_ok;
    logic             ar_free, b_hit;

    logic [CntW-1:0]  rd_cnt_q [NPORT];
    logic [CntW-1:0]  rd_cnt_d [NPORT];
    logic             wr_busy_q, wr_busy_d;

    logic             arvalid_q, arvalid_d;
    logic [31:0]      araddr_q, araddr_d;
    logic [ID_W-1:0]  arid_q, arid_d;
    logic [2:0]       arsize_q, arsize_d;

    logic             awvalid_q, awvalid_d;
    logic             wvalid_q, wvalid_d;
    logic [31:0]      awaddr_q, awaddr_d;
    logic [ID_W-1:0]  awid_q, awid_d;
    logic [2:0]       awsize_q, awsize_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;

    logic             unused_resp;
    assign unused_resp = ^{bus.rresp, bus.bresp, bus.rlast};

    always_comb begin
        b_hit = 1'b0;
        for (int i = 0; i < NPORT; i++) begin
            port_addr[i] = bus.addr[32*i +: 32];
            // A read to the word the in-flight write targets must wait for its response
            rd_elig[i] = bus.req[i] & ~bus.wr[i] & (rd_cnt_q[i] < CntW'(MAX_OUT))
                       & ~(wr_busy_q & (awid_q == ID_W'(i)))
                       & ~(wr_busy_q & (awaddr_q[31:2] == port_addr[i][31:2]));
            wr_elig[i] = bus.req[i] & bus.wr[i] & (rd_cnt_q[i] == '0) & ~wr_busy_q;
            rd_dec[i]  = bus.rvalid & (bus.rid == ID_W'(i));
            data_ok[i] = rd_dec[i] | (bus.bvalid & (bus.bid == ID_W'(i)));
            b_hit      = b_hit | (bus.bvalid & (bus.bid == ID_W'(i)));
        end
    end

    assign ar_free = ~arvalid_q | bus.arready;
    assign rd_acc  = ar_free ? rd_gnt : '0;

    rr_arbiter #(.N(NPORT)) u_rd_arb (
        .clk     (aclk),
        .rst     (areset),
        .req     (rd_elig),
        .advance (ar_free),
        .grant   (rd_gnt)
    );

    rr_arbiter #(.N(NPORT)) u_wr_arb (
        .clk     (aclk),
        .rst     (areset),
        .req     (wr_elig),
        .advance (1'b1),
        .grant   (wr_gnt)
    );

    always_comb begin
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        arid_d    = arid_q;
        arsize_d  = arsize_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        awaddr_d  = awaddr_q;
        awid_d    = awid_q;
        awsize_d  = awsize_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wr_busy_d = wr_busy_q;

        if (arvalid_q && bus.arready) arvalid_d = 1'b0;
        if (awvalid_q && bus.awready) awvalid_d = 1'b0;
        if (wvalid_q && bus.wready)   wvalid_d  = 1'b0;
        if (b_hit)                    wr_busy_d = 1'b0;

        for (int i = 0; i < NPORT; i++) begin
            rd_cnt_d[i] = rd_cnt_q[i];
            if (rd_acc[i] && !rd_dec[i]) begin
                rd_cnt_d[i] = rd_cnt_q[i] + CntW'(1);
            end else if (!rd_acc[i] && rd_dec[i] && (rd_cnt_q[i] != '0)) begin
                rd_cnt_d[i] = rd_cnt_q[i] - CntW'(1);
            end

            if (rd_acc[i]) begin
                arvalid_d = 1'b1;
                araddr_d  = port_addr[i];
                arid_d    = ID_W'(i);
                arsize_d  = axsize(bus.size[2*i +: 2]);
            end

            if (wr_gnt[i]) begin
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                wr_busy_d = 1'b1;
                awaddr_d  = port_addr[i];
                awid_d    = ID_W'(i);
                awsize_d  = axsize(bus.size[2*i +: 2]);
                wdata_d   = bus.sram_wdata[32*i +: 32];
                wstrb_d   = bus.sram_wstrb[4*i +: 4];
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arid_q    <= '0;
            arsize_q  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            awid_q    <= '0;
            awsize_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wr_busy_q <= 1'b0;
            for (int i = 0; i < NPORT; i++) rd_cnt_q[i] <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arid_q    <= arid_d;
            arsize_q  <= arsize_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            awaddr_q  <= awaddr_d;
            awid_q    <= awid_d;
            awsize_q  <= awsize_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wr_busy_q <= wr_busy_d;
            for (int i = 0; i < NPORT; i++) rd_cnt_q[i] <= rd_cnt_d[i];
        end
    end

    // Handshake outputs are forced low while reset is held
    assign bus.addr_ok = areset ? '0 : (rd_acc | wr_gnt);
    assign bus.data_ok = areset ? '0 : data_ok;
    assign bus.rdata_o = areset ? '0 : bus.rdata;

    assign bus.arid    = arid_q;
    assign bus.araddr  = araddr_q;
    assign bus.arlen   = LEN_SINGLE;
    assign bus.arsize  = arsize_q;
    assign bus.arburst = BURST_INCR;
    assign bus.arlock  = '0;
    assign bus.arcache = '0;
    assign bus.arprot  = '0;
    assign bus.arvalid = arvalid_q;
    assign bus.rready  = 1'b1;

    assign bus.awid    = awid_q;
    assign bus.awaddr  = awaddr_q;
    assign bus.awlen   = LEN_SINGLE;
    assign bus.awsize  = awsize_q;
    assign bus.awburst = BURST_INCR;
    assign bus.awlock  = '0;
    assign bus.awcache = '0;
    assign bus.awprot  = '0;
    assign bus.awvalid = awvalid_q;

    assign bus.wid     = awid_q;
    assign bus.wdata   = wdata_q;
    assign bus.wstrb   = wstrb_q;
    assign bus.wlast   = 1'b1;
    assign bus.wvalid  = wvalid_q;
    assign bus.bready  = 1'b1;

endmodule
